// File: rtl/mul_share_arbiter_pkg.sv
// Shared types and constants for the multiplier-sharing arbiter.
//   WIDTH/Q_BITS : fixed-point operand format (unsigned, Q_BITS fractional bits)
//   N_REQ        : number of requesters sharing the multiplier
//   FIFO_DEPTH   : default response FIFO depth
package mul_share_arbiter_pkg;

    localparam int unsigned WIDTH      = 32;
    localparam int unsigned Q_BITS     = 16;
    localparam int unsigned N_REQ      = 4;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned TAG_W      = $clog2(N_REQ);

    typedef logic [TAG_W-1:0] mul_tag_t;

    // One FIFO entry: which requester issued the op, and its product.
    typedef struct packed {
        mul_tag_t           tag;
        logic [WIDTH-1:0]   result;
    } mul_rsp_t;

    // Round-robin successor of a requester index.
    function automatic mul_tag_t tag_inc(input mul_tag_t t);
        return (32'(t) == N_REQ - 1) ? '0 : t + 1'b1;
    endfunction

endpackage

// File: rtl/multiplication.sv
// Single-cycle unsigned fixed-point multiplier (no reset on its datapath).
//   start_i      : capture a_i*b_i this cycle
//   a_i, b_i     : operands
//   result_o     : (a*b)[WIDTH+Q_BITS-1:Q_BITS], truncated, one cycle after start_i
//   valid_o      : start_i delayed one cycle (undefined until first clock)
module multiplication #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned Q_BITS = 16
) (
    input  logic             clk,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic             valid_o
);

    localparam int unsigned PW = 2 * WIDTH;

    logic [WIDTH-1:0] result_q;
    logic             valid_q;

    // Full-width product, shifted down by the fraction and truncated.
    always_ff @(posedge clk) begin
        valid_q <= start_i;
        if (start_i) begin
            result_q <= WIDTH'((PW'(a_i) * PW'(b_i)) >> Q_BITS);
        end
    end

    assign result_o = result_q;
    assign valid_o  = valid_q;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i : request vector
//   ptr_i : highest-priority index for this cycle
//   en_i  : grant enable; when low no grant is produced
//   gnt_o : one-hot (or zero) grant, first request at or above ptr_i with wrap
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    input  logic                 en_i,
    output logic [N-1:0]         gnt_o
);

    localparam int unsigned PW = $clog2(N);

    logic [PW-1:0] idx;
    logic          found;

    // Walk the requests starting at ptr_i; the first hit wins.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = PW'((32'(ptr_i) + k) % N);
            if (en_i && !found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one multiplier between N_REQ requesters with round-robin arbitration.
// Products return through an in-order response FIFO; issue is gated by credits
// so the FIFO can never overflow.
//   req_valid/req_ready : per-requester request handshake (ready is the grant)
//   req_a/req_b         : packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready : one-hot response valid for the FIFO head's requester
//   rsp_result          : head product (zero when FIFO empty)
//   idle                : nothing in flight and FIFO empty
module mul_share_arbiter
    import mul_share_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
    output logic [N_REQ-1:0]         rsp_valid,
    input  logic [N_REQ-1:0]         rsp_ready,
    output logic [WIDTH-1:0]         rsp_result,
    output logic                     idle
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    mul_tag_t           rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0]   gnt;
    logic               can_issue;
    logic               issue;
    mul_tag_t           gnt_idx;
    logic [WIDTH-1:0]   mul_a, mul_b, mul_result;
    logic               mul_valid_unused;

    logic               inflight_v_q;
    mul_tag_t           inflight_tag_q;

    mul_rsp_t           mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W:0]     occupancy;
    mul_rsp_t           head;
    logic               has_rsp;
    logic               push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    // Credits: FIFO entries plus the product still in the multiplier. A pop in
    // this cycle is deliberately not credited, keeping rsp_ready off req_ready.
    assign occupancy = {1'b0, count_q} + (CNT_W + 1)'(inflight_v_q);
    assign can_issue = occupancy < (CNT_W + 1)'(DEPTH);

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .en_i  (can_issue),
        .gnt_o (gnt)
    );

    assign req_ready = gnt;
    assign issue     = |gnt;

    // Encode the grant and steer the winner's operands to the multiplier.
    always_comb begin
        gnt_idx = '0;
        mul_a   = '0;
        mul_b   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                gnt_idx = TAG_W'(i);
                mul_a   = req_a[i*WIDTH +: WIDTH];
                mul_b   = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign rr_ptr_d = issue ? tag_inc(gnt_idx) : rr_ptr_q;

    // The multiplier's own valid is unreset; inflight_v_q tracks it instead.
    multiplication #(
        .WIDTH  (WIDTH),
        .Q_BITS (Q_BITS)
    ) u_mul (
        .clk      (clk),
        .start_i  (issue),
        .a_i      (mul_a),
        .b_i      (mul_b),
        .result_o (mul_result),
        .valid_o  (mul_valid_unused)
    );

    assign head    = mem_q[rd_ptr_q];
    assign has_rsp = count_q != '0;
    assign push    = inflight_v_q;
    assign pop     = has_rsp && rsp_ready[head.tag];

    // Only the head requester's valid is raised; other rsp_ready bits are ignored.
    always_comb begin
        rsp_valid = '0;
        if (has_rsp) begin
            rsp_valid[head.tag] = 1'b1;
        end
    end

    assign rsp_result = has_rsp ? head.result : '0;
    assign idle       = !inflight_v_q && !has_rsp;

    // Control state: arbitration pointer, in-flight tracking, FIFO pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q       <= '0;
            inflight_v_q   <= 1'b0;
            inflight_tag_q <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            inflight_v_q <= issue;
            if (issue) begin
                inflight_tag_q <= gnt_idx;
            end
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // FIFO storage; contents are only observed through count_q, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{tag: inflight_tag_q, result: mul_result};
        end
    end

endmodule

// File: tb/tb_mul_share_arbiter.sv
module tb_mul_share_arbiter;

    localparam int unsigned W = 32;
    localparam int unsigned N = 4;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
    } op_t;

    typedef struct {
        logic [1:0]   tag;
        logic [W-1:0] res;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     rsp_valid;
    logic [N-1:0]     rsp_ready;
    logic [W-1:0]     rsp_result;
    logic             idle;

    int               checks   = 0;
    int               failures = 0;

    op_t              op_q [N][$];
    exp_t             exp_q [$];
    int               gnt_log [$];
    logic [N-1:0]     last_gnt;
    logic [N-1:0]     last_rspv;
    logic             last_idle;

    mul_share_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    function automatic op_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] r);
        op_t o;
        o.a   = a;
        o.b   = b;
        o.res = r;
        return o;
    endfunction

    // Monitor: pops the scoreboard whenever a response handshake is visible.
    always @(negedge clk) begin : monitor
        int   tag;
        exp_t e;
        if (rst_n) begin
            chk("rsp_onehot", 64'($onehot0(rsp_valid)), 64'(1));
            if ((rsp_valid & rsp_ready) != '0) begin
                tag = 0;
                for (int i = 0; i < N; i++) if (rsp_valid[i]) tag = i;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp actual_tag=%0d actual=0x%0h required=none", tag, rsp_result);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_tag", 64'(tag), 64'(e.tag));
                    chk("rsp_result", 64'(rsp_result), 64'(e.res));
                end
            end
        end
    end

    // One clock: drive heads of the op queues, observe at negedge, log handshakes.
    task automatic cycle();
        for (int i = 0; i < N; i++) begin
            if (op_q[i].size() != 0) begin
                req_valid[i]       = 1'b1;
                req_a[i*W +: W]    = op_q[i][0].a;
                req_b[i*W +: W]    = op_q[i][0].b;
            end else begin
                req_valid[i]       = 1'b0;
                req_a[i*W +: W]    = '0;
                req_b[i*W +: W]    = '0;
            end
        end
        @(negedge clk);
        last_gnt  = req_ready;
        last_rspv = rsp_valid;
        last_idle = idle;
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                exp_q.push_back('{tag: 2'(i), res: op_q[i][0].res});
                gnt_log.push_back(i);
                void'(op_q[i].pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < N; i++) op_q[i].delete();
        exp_q.delete();
        gnt_log.delete();
        rst_n = 1'b0;
        #1;
        chk("reset_req_ready", 64'(req_ready), 64'(0));
        chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("reset_rsp_result", 64'(rsp_result), 64'(0));
        chk("reset_idle", 64'(idle), 64'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((exp_q.size() != 0 || !idle) && n < 60) begin
            cycle();
            n++;
        end
        chk(nm, 64'(exp_q.size() == 0 && idle), 64'(1));
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin : stim
        int bad;
        logic [11:0] rsp_hist, gnt_hist;
        logic [N-1:0] seen;
        int exp_seq [8];

        rst_n     = 1'b0;
        rsp_ready = '1;
        reset_dut();

        // 1. single op, latency
        op_q[0].push_back(mk(32'h0002_0000, 32'h0003_0000, 32'h0006_0000));
        cycle();
        chk("t1_grant_same_cycle", 64'(last_gnt), 64'(4'b0001));
        cycle();
        chk("t1_no_rsp_t1", 64'(last_rspv), 64'(0));
        chk("t1_busy", 64'(last_idle), 64'(0));
        cycle();
        chk("t1_rsp_t2", 64'(last_rspv), 64'(4'b0001));
        drain("t1_drain");

        // 2. all four at once from rr_ptr=0
        reset_dut();
        for (int i = 0; i < N; i++) op_q[i].push_back(mk(32'h0001_8000, 32'h0000_8000, 32'h0000_C000));
        for (int k = 0; k < 4; k++) cycle();
        bad = 0;
        for (int k = 0; k < gnt_log.size(); k++) if (gnt_log[k] != k) bad++;
        chk("t2_grant_count", 64'(gnt_log.size()), 64'(4));
        chk("t2_grant_order", 64'(bad), 64'(0));
        drain("t2_drain");

        // 3. req0 and req2 held continuously: strict alternation
        reset_dut();
        for (int k = 0; k < 50; k++) begin
            op_q[0].push_back(mk(32'h0002_0000, 32'h0000_4000, 32'h0000_8000));
            op_q[2].push_back(mk(32'h0002_0000, 32'h0000_4000, 32'h0000_8000));
        end
        for (int k = 0; k < 100; k++) cycle();
        bad = 0;
        for (int k = 0; k < gnt_log.size(); k++) if (gnt_log[k] != ((k % 2 == 0) ? 0 : 2)) bad++;
        chk("t3_grant_count", 64'(gnt_log.size()), 64'(100));
        chk("t3_alternation", 64'(bad), 64'(0));
        drain("t3_drain");

        // 4. backpressure: exactly DEPTH grants, non-head ready ignored, resume
        reset_dut();
        rsp_ready = '0;
        op_q[0].push_back(mk(32'h0001_0000, 32'h0000_8000, 32'h0000_8000));
        op_q[0].push_back(mk(32'h0005_0000, 32'h0000_8000, 32'h0002_8000));
        op_q[1].push_back(mk(32'h0002_0000, 32'h0000_8000, 32'h0001_0000));
        op_q[1].push_back(mk(32'h0006_0000, 32'h0000_8000, 32'h0003_0000));
        op_q[2].push_back(mk(32'h0003_0000, 32'h0000_8000, 32'h0001_8000));
        op_q[2].push_back(mk(32'h0007_0000, 32'h0000_8000, 32'h0003_8000));
        op_q[3].push_back(mk(32'h0004_0000, 32'h0000_8000, 32'h0002_0000));
        op_q[3].push_back(mk(32'h0008_0000, 32'h0000_8000, 32'h0004_0000));
        for (int k = 0; k < 6; k++) cycle();
        chk("t4_grants_when_full", 64'(gnt_log.size()), 64'(4));
        chk("t4_ready_low_full", 64'(last_gnt), 64'(0));
        rsp_ready = 4'b1110;
        for (int k = 0; k < 3; k++) cycle();
        chk("t4_nonhead_ignored_gnt", 64'(last_gnt), 64'(0));
        chk("t4_head_held", 64'(last_rspv), 64'(4'b0001));
        chk("t4_grants_still", 64'(gnt_log.size()), 64'(4));
        rsp_ready = '1;
        drain("t4_drain");
        exp_seq = '{0, 1, 2, 3, 0, 1, 2, 3};
        bad = 0;
        for (int k = 0; k < gnt_log.size() && k < 8; k++) if (gnt_log[k] != exp_seq[k]) bad++;
        chk("t4_total_grants", 64'(gnt_log.size()), 64'(8));
        chk("t4_grant_order", 64'(bad), 64'(0));

        // 5. reset mid-operation discards everything
        reset_dut();
        rsp_ready = '0;
        for (int k = 0; k < 3; k++) op_q[1].push_back(mk(32'h0001_0000, 32'h0001_0000, 32'h0001_0000));
        for (int k = 0; k < 3; k++) cycle();
        chk("t5_pre_rsp_valid", 64'(rsp_valid), 64'(4'b0010));
        chk("t5_pre_idle", 64'(idle), 64'(0));
        reset_dut();
        rsp_ready = '1;
        seen = '0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            seen = seen | last_rspv;
        end
        chk("t5_no_stale_rsp", 64'(seen), 64'(0));
        chk("t5_idle_after", 64'(idle), 64'(1));

        // 6. back-to-back stream from req3, includes truncation/overflow vectors
        reset_dut();
        rsp_ready = 4'b1000;
        op_q[3].push_back(mk(32'h0001_0000, 32'h0003_0000, 32'h0003_0000));
        op_q[3].push_back(mk(32'h0002_0000, 32'h0003_0000, 32'h0006_0000));
        op_q[3].push_back(mk(32'h0004_0000, 32'h0003_0000, 32'h000C_0000));
        op_q[3].push_back(mk(32'h0000_8000, 32'h0000_8000, 32'h0000_4000));
        op_q[3].push_back(mk(32'h0000_0001, 32'h0000_0001, 32'h0000_0000));
        op_q[3].push_back(mk(32'h8000_0000, 32'h0002_0000, 32'h0000_0000));
        op_q[3].push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFE_0000));
        op_q[3].push_back(mk(32'h0003_0000, 32'hFFFF_0000, 32'hFFFD_0000));
        rsp_hist = '0;
        gnt_hist = '0;
        for (int k = 0; k < 12; k++) begin
            cycle();
            rsp_hist[k] = last_rspv[3];
            gnt_hist[k] = last_gnt[3];
        end
        chk("t6_grant_stream", 64'(gnt_hist), 64'(12'b0000_1111_1111));
        chk("t6_rsp_stream", 64'(rsp_hist), 64'(12'b0011_1111_1100));
        drain("t6_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
